// File: rtl/polyvecl_pack_eta.sv
// polyvecl_pack_eta
// Serialises a length-L vector of eta-bounded polynomials into the secret-key
// byte string. Each coefficient c becomes the nibble (ETA - c)[3:0], two
// nibbles per byte, even coefficient in the low nibble. CPC coefficients are
// packed per clock under a level start / done handshake.
//
// Because CPC coefficients occupy exactly 32*CPC input bits and 4*CPC output
// bits, group g maps linearly onto v_in[g*32*CPC +: 32*CPC] and
// packed_out[g*4*CPC +: 4*CPC] regardless of polynomial boundaries, which
// keeps the datapath a single indexed slice on each side.
module polyvecl_pack_eta #(
    parameter int L   = 5,
    parameter int ETA = 4,
    parameter int CPC = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [32*256*L-1:0]   v_in,
    output logic [1024*L-1:0]     packed_out,
    output logic                  done,
    output logic                  busy,
    output logic                  range_err
);

    localparam int IN_BITS   = 32 * 256 * L;
    localparam int OUT_BITS  = 1024 * L;
    localparam int GROUPS    = (L * 256) / CPC;
    localparam int GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int IN_W      = 32 * CPC;
    localparam int OUT_W     = 4 * CPC;
    localparam int IN_OFF_W  = $clog2(IN_BITS);
    localparam int OUT_OFF_W = $clog2(OUT_BITS);

    localparam logic [GW-1:0]      LAST_G    = GW'(GROUPS - 1);
    localparam logic signed [31:0] ETA_POS_S = 32'(ETA);
    localparam logic signed [31:0] ETA_NEG_S = 32'(-ETA);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_LOAD       = 3'd2,
        S_PACK       = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    // Nibble stored for one coefficient: low four bits of ETA - c, computed
    // in 32-bit signed arithmetic so out-of-range values wrap predictably.
    function automatic logic [3:0] eta_nibble(input logic signed [31:0] c);
        logic signed [31:0] t;
        t = ETA_POS_S - c;
        return t[3:0];
    endfunction

    // True when a coefficient lies outside the legal range [-ETA, ETA].
    function automatic logic eta_out_of_range(input logic signed [31:0] c);
        return (c < ETA_NEG_S) || (c > ETA_POS_S);
    endfunction

    state_t                 state_q, state_d;
    logic [GW-1:0]          g_q, g_d;
    logic [OUT_BITS-1:0]    packed_q, packed_d;
    logic                   range_err_q, range_err_d;
    logic                   done_q;
    logic                   busy_q;

    logic [IN_OFF_W-1:0]    in_off_s;
    logic [OUT_OFF_W-1:0]   out_off_s;
    logic [IN_W-1:0]        grp_in_s;
    logic [OUT_W-1:0]       grp_nib_s;
    logic                   grp_oor_s;

    // Bit offsets of the current group on the input and output vectors.
    always_comb begin
        in_off_s  = IN_OFF_W'(g_q) * IN_OFF_W'(IN_W);
        out_off_s = OUT_OFF_W'(g_q) * OUT_OFF_W'(OUT_W);
    end

    assign grp_in_s = v_in[in_off_s +: IN_W];

    // Convert the CPC coefficients of the current group to nibbles and flag any out-of-range value.
    always_comb begin
        grp_nib_s = '0;
        grp_oor_s = 1'b0;
        for (int k = 0; k < CPC; k++) begin
            grp_nib_s[4*k +: 4] = eta_nibble(grp_in_s[32*k +: 32]);
            grp_oor_s           = grp_oor_s | eta_out_of_range(grp_in_s[32*k +: 32]);
        end
    end

    // Next-state logic for the handshake FSM, the group counter and the packed image.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        packed_d    = packed_q;
        range_err_d = range_err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_WAIT_START;
                end
            end
            S_LOAD: begin
                g_d         = '0;
                packed_d    = '0;
                range_err_d = 1'b0;
                state_d     = S_PACK;
            end
            S_PACK: begin
                packed_d[out_off_s +: OUT_W] = grp_nib_s;
                range_err_d                  = range_err_q | grp_oor_s;
                if (g_q == LAST_G) begin
                    g_d     = g_q;
                    state_d = S_DONE;
                end else begin
                    g_d     = g_q + GW'(1);
                    state_d = S_PACK;
                end
            end
            S_DONE: begin
                // A start still held high here must not retrigger; only a
                // low start lets the block return through IDLE.
                if (start) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, data and status registers with synchronous reset; done/busy are registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            packed_q    <= '0;
            range_err_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            packed_q    <= packed_d;
            range_err_q <= range_err_d;
            done_q      <= (state_d == S_DONE);
            busy_q      <= (state_d == S_LOAD) || (state_d == S_PACK);
        end
    end

    assign packed_out = packed_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_polyvecl_pack_eta.sv
// Self-checking bench for polyvecl_pack_eta. Coefficients live in an integer
// array; the expected byte image and range flag are computed from it with
// plain arithmetic, byte by byte, polynomial by polynomial.
module tb_polyvecl_pack_eta;

    localparam int L   = 5;
    localparam int ETA = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [32*256*L-1:0]  v_in;
    logic [1024*L-1:0]    packed_out;
    logic                 done;
    logic                 busy;
    logic                 range_err;

    int checks = 0;
    int fails  = 0;

    int                   coef [L][256];
    logic [1024*L-1:0]    exp_vec;
    logic                 exp_err;

    polyvecl_pack_eta #(.L(L), .ETA(ETA), .CPC(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .v_in       (v_in),
        .packed_out (packed_out),
        .done       (done),
        .busy       (busy),
        .range_err  (range_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Load v_in from coef[] and compute the reference image and range flag.
    task automatic build_and_model();
        int lo;
        int hi;
        exp_err = 1'b0;
        for (int p = 0; p < L; p++) begin
            for (int j = 0; j < 256; j++) begin
                v_in[8192*p + 32*j +: 32] = coef[p][j];
                if (coef[p][j] < -ETA || coef[p][j] > ETA) exp_err = 1'b1;
            end
            for (int i = 0; i < 128; i++) begin
                lo = (ETA - coef[p][2*i]) % 16;
                hi = (ETA - coef[p][2*i+1]) % 16;
                if (lo < 0) lo += 16;
                if (hi < 0) hi += 16;
                exp_vec[1024*p + 8*i +: 8] = 8'(hi * 16 + lo);
            end
        end
    endtask

    task automatic fill_const(input int value);
        for (int p = 0; p < L; p++)
            for (int j = 0; j < 256; j++)
                coef[p][j] = value;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag);
        int first;
        first = -1;
        checks++;
        assert (packed_out === exp_vec) else begin
            fails++;
            for (int i = 1024*L/8 - 1; i >= 0; i--)
                if (packed_out[8*i +: 8] !== exp_vec[8*i +: 8]) first = i;
            $error("FAIL %s: byte %0d observed %h expected %h", tag, first,
                   packed_out[8*first +: 8], exp_vec[8*first +: 8]);
        end
    endtask

    // Raise start (block assumed in WAIT_START) and wait for done; lat is edges after the sampling edge.
    task automatic run_op(input bit drop_mid, output int lat);
        int  cycles;
        bit  overlap;
        cycles  = 0;
        overlap = 1'b0;
        @(negedge clock);
        start = 1'b1;
        while (done !== 1'b1 && cycles < 300) begin
            @(posedge clock);
            #1;
            cycles++;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
            if (drop_mid && cycles == 10) start = 1'b0;
        end
        lat = cycles - 1;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_done_exclusive", {31'd0, overlap}, 32'd0);
    endtask

    // Drop start, confirm done falls on the next edge, then let the FSM reach WAIT_START.
    task automatic finish_op();
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("done_falls", {31'd0, done}, 32'd0);
        @(posedge clock);
    endtask

    initial begin
        int  lat;
        bit  bad;

        reset = 1'b1;
        start = 1'b0;
        v_in  = '0;
        repeat (3) @(posedge clock);
        #1;
        exp_vec = '0;
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_err", {31'd0, range_err}, 32'd0);
        chk_vec("reset_packed");
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // All zeros -> 0x44 everywhere, 81-cycle latency.
        fill_const(0);
        build_and_model();
        run_op(1'b0, lat);
        chk("zero_latency", lat, 32'd81);
        chk("zero_busy_in_done", {31'd0, busy}, 32'd0);
        chk("zero_byte0", {24'd0, packed_out[7:0]}, 32'h44);
        chk_vec("zero_image");
        chk("zero_err", {31'd0, range_err}, 32'd0);
        finish_op();

        // All +4 -> 0x00; all -4 -> 0x88.
        fill_const(4);
        build_and_model();
        run_op(1'b0, lat);
        chk("pos4_latency", lat, 32'd81);
        chk("pos4_last_byte", {24'd0, packed_out[1024*L-1 -: 8]}, 32'h00);
        chk_vec("pos4_image");
        chk("pos4_err", {31'd0, range_err}, 32'd0);
        finish_op();

        fill_const(-4);
        build_and_model();
        run_op(1'b0, lat);
        chk("neg4_byte_mid", {24'd0, packed_out[1024*2 + 8*50 +: 8]}, 32'h88);
        chk_vec("neg4_image");
        chk("neg4_err", {31'd0, range_err}, 32'd0);
        finish_op();

        // Ramp: ((j + p) mod 9) - 4.
        for (int p = 0; p < L; p++)
            for (int j = 0; j < 256; j++)
                coef[p][j] = ((j + p) % 9) - 4;
        build_and_model();
        run_op(1'b0, lat);
        chk("ramp_p0_b0", {24'd0, packed_out[7:0]}, 32'h78);
        chk("ramp_p1_b0", {24'd0, packed_out[1024 +: 8]}, 32'h67);
        chk_vec("ramp_image");
        chk("ramp_err", {31'd0, range_err}, 32'd0);
        finish_op();

        // Single +5 at polynomial 3 index 200.
        fill_const(0);
        coef[3][200] = 5;
        build_and_model();
        run_op(1'b0, lat);
        chk("single_err", {31'd0, range_err}, 32'd1);
        chk("single_byte", {24'd0, packed_out[1024*3 + 8*100 +: 8]}, 32'h4F);
        chk_vec("single_image");
        finish_op();

        // Random legal coefficients, then random images with wild values injected.
        for (int it = 0; it < 3; it++) begin
            for (int p = 0; p < L; p++)
                for (int j = 0; j < 256; j++) begin
                    coef[p][j] = int'($urandom_range(8, 0)) - 4;
                    if (it > 0 && $urandom_range(63, 0) == 0) coef[p][j] = int'($urandom);
                end
            if (it > 0) coef[it][it * 7] = -5 - it;
            build_and_model();
            run_op(1'b0, lat);
            chk("rand_latency", lat, 32'd81);
            chk_vec("rand_image");
            chk("rand_err", {31'd0, range_err}, {31'd0, exp_err});
            finish_op();
        end

        // Reset 30 cycles into PACK, then a normal operation.
        for (int p = 0; p < L; p++)
            for (int j = 0; j < 256; j++)
                coef[p][j] = ((j + p) % 9) - 4;
        coef[0][0] = 7;
        build_and_model();
        @(negedge clock);
        start = 1'b1;
        repeat (31) @(posedge clock);
        #1;
        chk("midpack_busy", {31'd0, busy}, 32'd1);
        chk("midpack_err_set", {31'd0, range_err}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1;
        exp_vec = '0;
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_err", {31'd0, range_err}, 32'd0);
        chk_vec("rst_mid_packed");
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        coef[0][0] = -4;
        build_and_model();
        run_op(1'b0, lat);
        chk("post_rst_latency", lat, 32'd81);
        chk_vec("post_rst_image");
        chk("post_rst_err", {31'd0, range_err}, 32'd0);
        finish_op();

        // start dropped mid-PACK: done is a one-cycle pulse.
        for (int p = 0; p < L; p++)
            for (int j = 0; j < 256; j++)
                coef[p][j] = int'($urandom_range(8, 0)) - 4;
        build_and_model();
        run_op(1'b1, lat);
        chk("drop_latency", lat, 32'd81);
        chk_vec("drop_image");
        @(posedge clock);
        #1;
        chk("drop_pulse_width", {31'd0, done}, 32'd0);
        chk("drop_busy_after", {31'd0, busy}, 32'd0);
        @(posedge clock);

        // start held 20 cycles past done: no retrigger.
        fill_const(-1);
        build_and_model();
        run_op(1'b0, lat);
        bad = 1'b0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (done !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        chk("held_done_stays", {31'd0, bad}, 32'd0);
        chk("held_byte0", {24'd0, packed_out[7:0]}, 32'h55);
        chk_vec("held_image");
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/polyvecl_pack_eta.md
# polyvecl_pack_eta

Packs a length-L vector of eta-bounded polynomials (the secret vector s1, as produced by the eta sampler) into the secret-key byte string. Coefficients are 32-bit signed. For each coefficient, t = ETA − coeff is stored as a 4-bit nibble, two per byte. The block is the serialising counterpart of the uniform-eta sampler: it consumes the sampler's flat 40960-bit vector and feeds the secret-key assembly stage. It processes a fixed number of coefficients per cycle under a start/done handshake.

## Interface
- L, 5, number of polynomials in the vector
- ETA, 4, coefficient bound; the legal coefficient range is [−ETA, ETA]
- CPC, 16, coefficients packed per cycle; must divide 256
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  level request; held high until done is seen
- v_in  input  32·256·L (40960)  polynomial p, coefficient j at v_in[8192·p + 32·j +: 32], two's complement; must be held stable from start until done
- packed_out  output  1024·L (5120)  registered; byte i of polynomial p at packed_out[1024·p + 8·i +: 8]
- done  output  1  high only in state DONE
- busy  output  1  high in LOAD and PACK
- range_err  output  1  sticky per operation; set if any coefficient lies outside [−ETA, ETA]

## Operation
- States: IDLE, WAIT_START, LOAD, PACK, DONE.
- IDLE → WAIT_START unconditionally after 1 cycle.
- WAIT_START → LOAD when start = 1.
- LOAD:
  - Clears the group counter g, packed_out and range_err.
  - → PACK.
- PACK, per cycle, for group g (polynomial p = g / (256/CPC), coefficient base b = (g mod (256/CPC))·CPC):
  - For k in 0..CPC−1, compute t = ETA − v_in coefficient (b+k), using 32-bit signed arithmetic.
  - Write t[3:0] into nibble b+k of polynomial p.
  - Even coefficient index → byte (b+k)/2 bits [3:0]; odd → bits [7:4].
  - If any coefficient is < −ETA or > ETA, set range_err. Its nibble is still written as t[3:0].
  - g increments each cycle. After the last group (L·256/CPC − 1 = 79), → DONE.
- DONE:
  - done = 1; packed_out and range_err are held.
  - When start = 0, → IDLE. While start = 1, stay in DONE.
- start changes during LOAD/PACK are ignored; the operation always runs to completion.
- A new operation requires passing through IDLE and WAIT_START. A start held high across DONE does not retrigger.
- Legal-range mapping: coeff −4..4 → t 8..0. For example coeff 0 → 0x4 and a pair of zeros → byte 0x44.

## Timing
- Reset values: state IDLE, done 0, busy 0, range_err 0, packed_out all zeros, g 0.
- Reset is honoured in any state, including mid-PACK. It returns the block to IDLE and clears all outputs on the next edge.
- If start is sampled high at edge N (state WAIT_START):
  - LOAD during N..N+1.
  - PACK from edge N+1.
  - Groups 0..79 are written at edges N+2..N+81.
  - done rises after edge N+81, which is 81 cycles of latency.
- packed_out bytes for group g are final after edge N+2+g. Bytes are not guaranteed final before done.
- If start is deasserted before done, done is a one-cycle pulse: DONE → IDLE on the next edge.
- done falls on the edge after start is sampled low in DONE.
- busy and done are never high together.

## Test plan
- All-zero v_in, start held until done:
  - Every packed_out byte is 0x44.
  - range_err = 0.
  - done rises exactly 81 cycles after start is sampled.
- All coefficients +4 → all bytes 0x00. All coefficients −4 → all bytes 0x88. range_err = 0 in both cases.
- Ramp, coefficient j of polynomial p = ((j + p) mod 9) − 4:
  - Polynomial 0 byte 0 = 0x78 (t0 = 8, t1 = 7).
  - Polynomial 1 byte 0 = 0x67.
  - Every byte matches a software golden model.
- Single coefficient = +5 (polynomial 3, index 200), all other coefficients zero:
  - range_err = 1.
  - Polynomial 3 byte 100 = 0x4F (t = −1, low nibble 0xF).
  - All other bytes are 0x44.
- Reset asserted 30 cycles into PACK:
  - Next cycle: done 0, busy 0, packed_out 0, range_err 0.
  - A following start completes normally with correct data.
- Handshake checks:
  - start dropped mid-PACK → done pulses exactly one cycle, data correct.
  - start held high 20 cycles after done → done stays high, no second operation occurs.
